median_window_ctrl: RTL and testbench

Sequencer that feeds the 3x3 median filter from a single-port frame memory. On `start` it walks every pixel of a ROW x COL frame in address order and issues nine memory reads per pixel, clamping neighbours at the frame edges. It gathers the nine bytes into a window register and presents that window to the filter through a valid/ready handshake. It replaces the free-running pixel counter with a flow-controlled front end and produces a single `done` pulse per frame.

---
 rtl/median_window_ctrl.sv | 171 +++++++++++++++++
 tb/tb_median_window_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: walks a ROW x COL frame in address order and, for each
// centre pixel, gathers its edge-clamped 3x3 neighbourhood from a single-port
// 1-cycle-latency memory, then offers the window to the median filter through
// a valid/ready handshake. Emits one done pulse per completed frame.
module median_window_ctrl #(
    parameter int ROW = 430,
    parameter int COL = 554,
    parameter int AW  = 18,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DW-1:0]     rd_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [9*DW-1:0]   win_data,
    output logic [AW-1:0]     win_addr,
    output logic              win_last
);

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] R_MAX  = RW'(ROW - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(COL - 1);
    localparam logic [AW-1:0] STRIDE = AW'(ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [RW-1:0]          r;
    logic [CW-1:0]          c;
    logic [AW-1:0]          cen;
    logic [3:0]             k;
    logic                   cap_en;
    logic [3:0]             cap_k;
    logic [8:0][DW-1:0]     win_q;

    logic [RW-1:0]          nxt_r;
    logic [CW-1:0]          nxt_c;
    logic [AW-1:0]          nxt_cen;
    logic [AW-1:0]          fetch_addr;
    logic [AW-1:0]          hs_addr;

    assign win_data = win_q;

    // Slot address from the centre by +-1 / +-ROW steps; an offset is dropped
    // when it would leave the frame, which replicates the edge pixel.
    function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] a_cen,
                                                input logic [RW-1:0] a_r,
                                                input logic [CW-1:0] a_c,
                                                input logic [3:0]    a_k);
        logic [AW-1:0] a;
        a = a_cen;
        if (a_k <= 4'd2) begin
            if (a_r != '0) a = a - AW'(1);
        end else if (a_k >= 4'd6) begin
            if (a_r != R_MAX) a = a + AW'(1);
        end
        case (a_k)
            4'd0, 4'd3, 4'd6: if (a_c != '0)    a = a - STRIDE;
            4'd2, 4'd5, 4'd8: if (a_c != C_MAX) a = a + STRIDE;
            default: ;
        endcase
        return a;
    endfunction

    // Next-pixel coordinates and the next read address in each situation.
    always_comb begin
        nxt_r      = (r == R_MAX) ? '0 : r + RW'(1);
        nxt_c      = (r == R_MAX) ? c + CW'(1) : c;
        nxt_cen    = cen + AW'(1);
        fetch_addr = slot_addr(cen, r, c, k + 4'd1);
        hs_addr    = slot_addr(nxt_cen, nxt_r, nxt_c, 4'd0);
    end

    // Sequencer FSM: all outputs registered; read data lands in slot cap_k
    // one cycle after its read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            r         <= '0;
            c         <= '0;
            cen       <= '0;
            k         <= '0;
            cap_en    <= 1'b0;
            cap_k     <= '0;
            win_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            win_addr  <= '0;
            win_last  <= 1'b0;
        end else begin
            cap_en <= rd_en;
            cap_k  <= k;
            if (cap_en && (state == S_FETCH || state == S_WAIT))
                win_q[cap_k] <= rd_data;

            case (state)
                S_IDLE: begin
                    r   <= '0;
                    c   <= '0;
                    cen <= '0;
                    if (start) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= slot_addr('0, '0, '0, 4'd0);
                        k       <= '0;
                    end
                end
                S_FETCH: begin
                    if (k == 4'd8) begin
                        rd_en <= 1'b0;
                        state <= S_WAIT;
                    end else begin
                        k       <= k + 4'd1;
                        rd_addr <= fetch_addr;
                    end
                end
                S_WAIT: begin
                    state     <= S_PRESENT;
                    win_valid <= 1'b1;
                    win_addr  <= cen;
                    win_last  <= (r == R_MAX) && (c == C_MAX);
                end
                S_PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (win_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            r       <= nxt_r;
                            c       <= nxt_c;
                            cen     <= nxt_cen;
                            k       <= '0;
                            rd_en   <= 1'b1;
                            rd_addr <= hs_addr;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    win_last <= 1'b0;
                    r        <= '0;
                    c        <= '0;
                    cen      <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl on a 4x3 frame with a mem[a]=a RAM. A negedge
// monitor checks every read address, every handshake window and the done
// pulse against a clamp-and-multiply reference; directed sequences cover
// latency, backpressure, full-frame timing and mid-frame reset.
module tb_median_window_ctrl;

    localparam int ROW = 4;
    localparam int COL = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NPIX = ROW * COL;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              win_valid;
    logic              win_ready;
    logic [9*DW-1:0]   win_data;
    logic [AW-1:0]     win_addr;
    logic              win_last;

    int n_chk  = 0;
    int n_fail = 0;

    median_window_ctrl #(.ROW(ROW), .COL(COL), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_addr(win_addr), .win_last(win_last)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency RAM holding mem[a] = a.
    always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: address of slot k around pixel p, clamped at the frame edges.
    function automatic int m_addr(input int p, input int k);
        int rr, cc;
        rr = p % ROW + k / 3 - 1;
        cc = p / ROW + k % 3 - 1;
        if (rr < 0) rr = 0;
        if (rr > ROW - 1) rr = ROW - 1;
        if (cc < 0) cc = 0;
        if (cc > COL - 1) cc = COL - 1;
        return cc * ROW + rr;
    endfunction

    function automatic logic [9*DW-1:0] m_win(input int p);
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(m_addr(p, k));
        return w;
    endfunction

    // Monitor state
    int               cyc = 0;
    int               rd_idx = 0;
    int               hs_idx = 0;
    int               done_cnt = 0;
    int               hs_cyc[$];
    logic             exp_done = 1'b0;
    logic             prev_done = 1'b0;
    logic             prev_v = 1'b0;
    logic             prev_rdy = 1'b0;
    logic [9*DW-1:0]  prev_data = '0;
    logic [AW-1:0]    prev_addr = '0;

    // Negedge monitor: reads, stalls, handshakes and done against the model.
    always @(negedge clk) begin
        logic hs;
        cyc++;
        if (rst) begin
            rd_idx = 0; hs_idx = 0; exp_done = 1'b0; prev_done = 1'b0;
            prev_v = 1'b0; prev_rdy = 1'b0;
        end else begin
            chk("done", done, exp_done);
            if (prev_done) chk("busy_after_done", busy, 1'b0);
            if (done) done_cnt++;
            if (rd_en) begin
                chk("rd_addr", rd_addr, m_addr(rd_idx / 9, rd_idx % 9));
                chk("rd_while_valid", win_valid, 1'b0);
                rd_idx++;
            end
            if (prev_v && !prev_rdy) begin
                chk("stall_valid", win_valid, 1'b1);
                chk("stall_data", win_data, prev_data);
                chk("stall_addr", win_addr, prev_addr);
            end
            hs = win_valid && win_ready;
            if (hs) begin
                chk("win_data", win_data, m_win(hs_idx));
                chk("win_addr", win_addr, hs_idx);
                chk("win_last", win_last, hs_idx == NPIX - 1);
                hs_cyc.push_back(cyc);
                hs_idx++;
            end
            exp_done  = hs && win_last;
            prev_done = done;
            if (done) begin rd_idx = 0; hs_idx = 0; end
            prev_v    = win_valid;
            prev_rdy  = win_ready;
            prev_data = win_data;
            prev_addr = win_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run with random ready until done; a timeout is reported as a failure.
    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            win_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk({tag, "_timeout"}, n < 3000, 1'b1);
        win_ready = 1'b0;
        step();
    endtask

    initial begin
        logic [9*DW-1:0] held;
        int n;
        rst = 1'b1; start = 1'b1; win_ready = 1'b0;

        // Reset with start held high
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_valid", win_valid, 1'b0);
        chk("rst_last", win_last, 1'b0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_win_addr", win_addr, 0);
        chk("rst_win_data", win_data, 0);
        rst = 1'b0; start = 1'b0;
        step();

        // Start latency, pixel 0 window, backpressure
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            chk("lat_rd_en", rd_en, 1'b1);
            chk("lat_rd_addr", rd_addr, m_addr(0, j));
            chk("lat_busy", busy, 1'b1);
            step();
        end
        chk("lat_rd_off", rd_en, 1'b0);
        chk("lat_valid_lo", win_valid, 1'b0);
        step();
        chk("lat_valid_hi", win_valid, 1'b1);
        chk("p0_data", win_data, m_win(0));
        chk("p0_addr", win_addr, 0);
        chk("p0_last", win_last, 1'b0);
        held = win_data;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("bp_valid", win_valid, 1'b1);
            chk("bp_rd_en", rd_en, 1'b0);
            chk("bp_data", win_data, held);
        end
        win_ready = 1'b1;
        step();
        win_ready = 1'b0;
        chk("bp_next_rd", rd_en, 1'b1);
        chk("bp_next_addr", rd_addr, m_addr(1, 0));
        chk("bp_valid_drop", win_valid, 1'b0);
        run_to_done("frame1");
        chk("frame1_busy", busy, 1'b0);
        chk("frame1_hs", hs_cyc.size(), NPIX);
        chk("frame1_done", done_cnt, 1);

        // Full frame with ready tied high, stray start mid-frame
        hs_cyc.delete(); done_cnt = 0;
        win_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            start = (n == 40);
            step();
            n++;
        end
        start = 1'b0;
        chk("full_timeout", n < 400, 1'b1);
        step();
        win_ready = 1'b0;
        chk("full_hs", hs_cyc.size(), NPIX);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("full_spacing", hs_cyc[i] - hs_cyc[i-1], 11);
        chk("full_done", done_cnt, 1);
        chk("full_busy", busy, 1'b0);
        repeat (15) step();
        chk("full_stray_start", busy, 1'b0);
        chk("full_done_once", done_cnt, 1);

        // Reset during fetch of pixel 3, then restart from address 0
        hs_cyc.delete(); done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (hs_cyc.size() < 3 && n < 2000) begin
            win_ready = 1'b1 & 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("mid_timeout", n < 2000, 1'b1);
        win_ready = 1'b0;
        chk("mid_fetching", rd_en, 1'b1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_rd_en", rd_en, 1'b0);
        chk("mid_valid", win_valid, 1'b0);
        chk("mid_data", win_data, 0);
        repeat (20) step();
        chk("mid_no_done", done_cnt, 0);
        hs_cyc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_addr", rd_addr, 0);
        run_to_done("restart");
        chk("restart_hs", hs_cyc.size(), NPIX);
        chk("restart_done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
